// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, issues one outstanding
// request at a time to instruction memory over a req/ack handshake, buffers
// returned words in a small prefetch FIFO and presents {pc+4, instr} to decode.
// Execute-stage redirects flush the FIFO and drop any wrong-path fetch.
// Optional build macro IF_PERF_EN adds perf_fetched / perf_bubble counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstd,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble
`endif
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   buf_pc_q    [BUF_DEPTH];
    logic [31:0]   buf_instr_q [BUF_DEPTH];

    logic          req_c;
    logic          push_c;
    logic          pop_c;
    logic          credit_c;
    logic [31:0]   target_pc;
    logic [31:0]   push_pc;

    // Redirect targets are always word aligned; low two bits are dropped.
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    // The only time nothing is outstanding is IDLE, so credit is just FIFO room.
    assign credit_c  = (count_q < CW'(BUF_DEPTH));
    assign push_pc   = addr_q + 32'd4;

    // Request is raised combinationally in IDLE so a new fetch can start the
    // cycle after an ack; it is forced low while reset is asserted.
    assign imem_req  = rstd & req_c;
    // In IDLE the next fetch address is the PC; otherwise hold the in-flight
    // address (the PC may already point at a redirect target in DISCARD).
    assign imem_addr = (state_q == S_IDLE) ? pc_q : addr_q;

    assign valid_out = (count_q != '0);
    assign pc_out    = valid_out ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign instr_out = valid_out ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign pop_c     = valid_out & ~stall_d & ~redirect;

    // Fetch FSM: next state, PC, request and push decision.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_c   = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = target_pc;
                end else if (credit_c) begin
                    req_c   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    push_c  = 1'b1;
                    pc_d    = push_pc;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                req_c = 1'b1;
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy update; redirect empties the buffer outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: payload only, outputs are masked by valid_out.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
        // Capture {pc+4, instr} into the entry addressed by the write pointer.
        always_ff @(posedge clk) begin
            if (push_c && (wr_ptr_q == PW'(gi))) begin
                buf_pc_q[gi]    <= push_pc;
                buf_instr_q[gi] <= imem_rdata;
            end
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubble_q;

    // Wrapping counters: pushed fetches and empty-without-redirect cycles.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            perf_fetched_q <= 32'h0;
            perf_bubble_q  <= 32'h0;
        end else begin
            if (push_c) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!valid_out && !redirect) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed bench for if_stage with an in-bench
// transaction-level reference model (instruction queue + outstanding fetch).
`timescale 1ns/1ps
module tb_if_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_d = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rstd(rstd),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
        .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out)
`ifdef IF_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    // reference model
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    bit          m_out;
    bit          m_wrong;
    logic [31:0] m_fetched;
    logic [31:0] m_bubble;

    // memory responder
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;

    // knobs
    int stall_pct = 0;
    int redir_pct = 0;
    int lat_min   = 1;
    int lat_max   = 1;
    bit data_mode = 1'b0;
    bit redir_req = 1'b0;
    bit redir_on_ack = 1'b0;
    bit redir_no_ack = 1'b0;
    bit fired = 1'b0;
    logic [31:0] redir_tgt = 32'h0;

    // logs
    logic [31:0] start_log[$];
    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_instr_log[$];
    logic [31:0] snap_valid[$];
    logic [31:0] snap_pc[$];
    logic [31:0] snap_instr[$];
    logic [31:0] snap_req[$];
    logic [31:0] snap_addr[$];
    logic        last_valid, last_req;
    logic [31:0] last_addr;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %08h expected %08h", name, cyc, act, exp);
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_0BAD;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (data_mode) return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
        return a;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc = RST_PC; m_out_addr = RST_PC;
        m_out = 1'b0; m_wrong = 1'b0;
        m_fetched = 32'h0; m_bubble = 32'h0;
        mem_busy = 1'b0; mem_wait = 0; mem_addr = 32'h0;
    endtask

    task automatic clear_logs();
        start_log.delete(); pop_pc_log.delete(); pop_instr_log.delete();
        snap_valid.delete(); snap_pc.delete(); snap_instr.delete();
        snap_req.delete(); snap_addr.delete();
    endtask

    // Drive this cycle's inputs (called just after the rising edge).
    task automatic drive();
        int r;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            mem_wait--;
            if (mem_wait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(mem_addr);
            end
        end
        stall_d     = ($urandom_range(0, 99) < stall_pct);
        redirect    = 1'b0;
        redirect_pc = $urandom;
        fired       = 1'b0;
        if (redir_req && (!redir_on_ack || imem_ack) && (!redir_no_ack || !imem_ack)) begin
            redirect = 1'b1; redirect_pc = redir_tgt; redir_req = 1'b0; fired = 1'b1;
        end else if ($urandom_range(0, 99) < redir_pct) begin
            redirect = 1'b1;
            r = $urandom_range(0, 9);
            if (r < 2) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else       redirect_pc = $urandom & 32'h0000_0FFF;
        end
    endtask

    // Compare DUT against the model, then advance model and memory.
    task automatic sample();
        bit          e_valid, e_req;
        logic [31:0] e_pc, e_instr, e_addr;
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0][63:32] : 32'h0;
        e_instr = e_valid ? m_q[0][31:0]  : 32'h0;
        e_req   = m_out ? 1'b1 : ((m_q.size() < DEPTH) && !redirect);
        e_addr  = m_out ? m_out_addr : m_pc;
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("pc_out",    pc_out,    e_pc);
        chk("instr_out", instr_out, e_instr);
        chk("imem_req",  32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_addr);
`ifdef IF_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_bubble",  perf_bubble,  m_bubble);
`endif
        snap_valid.push_back(32'(valid_out)); snap_pc.push_back(pc_out);
        snap_instr.push_back(instr_out); snap_req.push_back(32'(imem_req));
        snap_addr.push_back(imem_addr);
        last_valid = valid_out; last_req = imem_req; last_addr = imem_addr;
        if (!redirect && valid_out && !stall_d) begin
            pop_pc_log.push_back(pc_out);
            pop_instr_log.push_back(instr_out);
        end
        if (!e_valid && !redirect) m_bubble++;
        if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (m_out && imem_ack) begin
                m_out = 1'b0; m_wrong = 1'b0;
            end else if (m_out) begin
                m_wrong = 1'b1;
            end
        end else begin
            if (e_valid && !stall_d) void'(m_q.pop_front());
            if (m_out && imem_ack) begin
                if (!m_wrong) begin
                    m_q.push_back({m_out_addr + 32'd4, imem_rdata});
                    m_pc = m_out_addr + 32'd4;
                    m_fetched++;
                end
                m_out = 1'b0; m_wrong = 1'b0;
            end else if (!m_out && e_req) begin
                m_out = 1'b1; m_out_addr = m_pc;
            end
        end
        if (imem_ack) begin
            mem_busy = 1'b0;
        end else if (imem_req && !mem_busy) begin
            mem_busy = 1'b1; mem_addr = imem_addr;
            mem_wait = $urandom_range(lat_min, lat_max);
            start_log.push_back(imem_addr);
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        sample();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstd = 1'b0; imem_ack = 1'b0; redirect = 1'b0; stall_d = 1'b0;
        redir_req = 1'b0; redir_on_ack = 1'b0; redir_no_ack = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_imem_req",  32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_pc_out",    pc_out, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        @(posedge clk); #1;
        rstd = 1'b1;
        clear_logs();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int idx;

        // Reset release, single-cycle memory, rdata = addr.
        do_reset();
        repeat (8) cycle();
        chk("p1_req_k0",   qget(snap_req, 0),   32'd1);
        chk("p1_addr_k0",  qget(snap_addr, 0),  32'h0);
        chk("p1_valid_k1", qget(snap_valid, 1), 32'd0);
        chk("p1_valid_k2", qget(snap_valid, 2), 32'd1);
        chk("p1_pc_k2",    qget(snap_pc, 2),    32'h4);
        chk("p1_instr_k2", qget(snap_instr, 2), 32'h0);
        chk("p1_pc_k4",    qget(snap_pc, 4),    32'h8);
        chk("p1_instr_k4", qget(snap_instr, 4), 32'h4);
        chk("p1_addr_k4",  qget(snap_addr, 4),  32'h8);

        // Decode stalled for 10 cycles: exactly DEPTH fetches, then none.
        do_reset();
        stall_pct = 100;
        repeat (10) cycle();
        chk("p2_req_count", 32'(start_log.size()), 32'(DEPTH));
        chk("p2_req_low",   qget(snap_req, 9), 32'd0);
        stall_pct = 0;
        repeat (10) cycle();
        chk("p2_pop0",   qget(pop_instr_log, 0), 32'h0);
        chk("p2_pop1",   qget(pop_instr_log, 1), 32'h4);
        chk("p2_resume", qget(start_log, 2),     32'h8);

        // Redirect while waiting on addr 8 with slow memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_busy && mem_addr == 32'h8) found = 1'b1;
            else cycle();
        end
        chk("p3_reach_wait8", 32'(found), 32'd1);
        redir_req = 1'b1; redir_tgt = 32'h100; redir_no_ack = 1'b1;
        cycle();
        redir_no_ack = 1'b0;
        chk("p3_fired", 32'(fired), 32'd1);
        pop_pc_log.delete(); pop_instr_log.delete();
        idx = start_log.size();
        repeat (14) cycle();
        chk("p3_next_addr",  qget(start_log, idx),    32'h100);
        chk("p3_first_inst", qget(pop_instr_log, 0),  32'h100);
        chk("p3_first_pc",   qget(pop_pc_log, 0),     32'h104);

        // Redirect in the same cycle as an ack, FIFO not empty.
        do_reset();
        lat_min = 1; lat_max = 1; stall_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_busy && mem_addr == 32'h4) found = 1'b1;
            else cycle();
        end
        chk("p4_reach_wait4", 32'(found), 32'd1);
        redir_req = 1'b1; redir_tgt = 32'h200; redir_on_ack = 1'b1;
        cycle();
        redir_on_ack = 1'b0;
        chk("p4_fired", 32'(fired), 32'd1);
        cycle();
        chk("p4_valid", 32'(last_valid), 32'd0);
        chk("p4_req",   32'(last_req),   32'd1);
        chk("p4_addr",  last_addr,       32'h200);
        stall_pct = 0;
        repeat (6) cycle();

        // Misaligned redirect target.
        do_reset();
        redir_req = 1'b1; redir_tgt = 32'h0000_0103;
        cycle();
        cycle();
        chk("p5_align_req",  32'(last_req), 32'd1);
        chk("p5_align_addr", last_addr,     32'h100);

        // PC wrap at the top of the address space.
        do_reset();
        redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFC;
        repeat (8) cycle();
        chk("p5_wrap_fetch", qget(start_log, 0),     32'hFFFF_FFFC);
        chk("p5_wrap_pc",    qget(pop_pc_log, 0),    32'h0);
        chk("p5_wrap_inst",  qget(pop_instr_log, 0), 32'hFFFF_FFFC);
        chk("p5_wrap_next",  qget(start_log, 1),     32'h0);

        // Asynchronous reset while a fetch is in flight.
        do_reset();
        lat_min = 4; lat_max = 4; stall_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_out && m_q.size() > 0) found = 1'b1;
            else cycle();
        end
        chk("p6_reach_wait", 32'(found), 32'd1);
        #2 rstd = 1'b0;
        #1;
        chk("p6_async_req",   32'(imem_req),  32'd0);
        chk("p6_async_valid", 32'(valid_out), 32'd0);
        imem_ack = 1'b0; redirect = 1'b0; stall_d = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rstd = 1'b1;
        clear_logs();
        lat_min = 1; lat_max = 1; stall_pct = 0;
        repeat (4) cycle();
        chk("p6_restart_addr", qget(start_log, 0), RST_PC);

        // Randomized traffic.
        do_reset();
        data_mode = 1'b1; lat_min = 1; lat_max = 4; stall_pct = 30; redir_pct = 5;
        repeat (3000) cycle();
        stall_pct = 0; redir_pct = 0; lat_min = 1; lat_max = 1;
        repeat (200) cycle();
        lat_min = 1; lat_max = 3; stall_pct = 60; redir_pct = 10;
        repeat (800) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
